// File: rtl/seq_mult.sv
// Sequential unsigned shift-and-add multiplier: one multiplier bit per clock,
// full-width registered product after MPLIER_WIDTH+1 clocks, start/done handshake.
module seq_mult #(
    parameter int MCAND_WIDTH  = 8,
    parameter int MPLIER_WIDTH = 8,
    parameter int PROD_WIDTH   = MCAND_WIDTH + MPLIER_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MCAND_WIDTH-1:0]  mcand_in,
    input  logic [MPLIER_WIDTH-1:0] mplier_in,
    output logic [PROD_WIDTH-1:0]   prod_out,
    output logic                    busy,
    output logic                    done
);

    // state | meaning
    // IDLE  | waiting for start; prod_out holds the last result
    // RUN   | one add/shift iteration per clock, MPLIER_WIDTH iterations
    // DONE  | publish the product and pulse done on the way back to IDLE

    localparam int CNT_WIDTH = (MPLIER_WIDTH > 2) ? $clog2(MPLIER_WIDTH) : 1;
    localparam int HI_WIDTH  = MCAND_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MPLIER_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state;
    logic [MCAND_WIDTH-1:0]   mcand_r;
    logic [PROD_WIDTH:0]      acc;
    logic [CNT_WIDTH-1:0]     cnt;

    logic [HI_WIDTH-1:0]      acc_hi_sum;
    logic [PROD_WIDTH:0]      acc_next;

    // The top acc bit is always 0 before the add, so the carry lands there
    // and is shifted back down into the product on the same edge.
    always_comb begin
        acc_hi_sum = acc[PROD_WIDTH:MPLIER_WIDTH];
        if (acc[0]) begin
            acc_hi_sum = acc[PROD_WIDTH:MPLIER_WIDTH] + {1'b0, mcand_r};
        end
        acc_next = {1'b0, acc_hi_sum, acc[MPLIER_WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            mcand_r  <= '0;
            acc      <= '0;
            cnt      <= '0;
            prod_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_r <= mcand_in;
                        acc     <= {{(HI_WIDTH){1'b0}}, mplier_in};
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_WIDTH'(1);
                    if (cnt == CNT_LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    prod_out <= acc[PROD_WIDTH-1:0];
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Scoreboard bench for seq_mult: default 8x8 instance plus a 12x4 instance,
// directed corner cases and random traffic against an arithmetic reference.
module tb_seq_mult;

    logic        clk;
    logic        rst;

    logic        start_a;
    logic [7:0]  mcand_a;
    logic [7:0]  mplier_a;
    logic [15:0] prod_a;
    logic        busy_a;
    logic        done_a;

    logic        start_b;
    logic [11:0] mcand_b;
    logic [3:0]  mplier_b;
    logic [15:0] prod_b;
    logic        busy_b;
    logic        done_b;

    seq_mult u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .start     (start_a),
        .mcand_in  (mcand_a),
        .mplier_in (mplier_a),
        .prod_out  (prod_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    seq_mult #(.MCAND_WIDTH(12), .MPLIER_WIDTH(4)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .start     (start_b),
        .mcand_in  (mcand_b),
        .mplier_in (mplier_b),
        .prod_out  (prod_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint prod;
        int     edge_n;
    } exp_t;

    exp_t   sb[2][$];
    int     k[2]         = '{-100, -100};
    longint last_prod[2] = '{0, 0};
    int     cyc          = 0;
    int     vec          = 0;
    int     err          = 0;

    // Reference: an operation accepted at edge k completes at edge k+N+1 and
    // the next request can be accepted from edge k+N+2 on.
    task automatic model_edge(input int d, input int n, input bit st,
                              input longint a, input longint b);
        exp_t e;
        if (!rst) return;
        if (st && cyc >= k[d] + n + 2) begin
            e.prod   = a * b;
            e.edge_n = cyc;
            sb[d].push_back(e);
            k[d] = cyc;
        end
    endtask

    task automatic mon(input int d, input int n, input bit dn, input bit bz,
                       input longint p);
        exp_t e;
        bit   exp_busy;
        exp_busy = rst && (cyc >= k[d]) && (cyc <= k[d] + n);
        vec++;
        if (bz !== exp_busy) begin
            err++;
            $display("FAIL busy[%0d] cyc=%0d got=%0d want=%0d", d, cyc, bz, exp_busy);
        end
        if (dn) begin
            if (sb[d].size() == 0) begin
                vec++;
                err++;
                $display("FAIL spurious_done[%0d] cyc=%0d prod=%0d want no done", d, cyc, p);
            end else begin
                e = sb[d].pop_front();
                vec++;
                if (p != e.prod) begin
                    err++;
                    $display("FAIL product[%0d] cyc=%0d got=%0d want=%0d", d, cyc, p, e.prod);
                end
                vec++;
                if (cyc != e.edge_n + n + 1) begin
                    err++;
                    $display("FAIL latency[%0d] got=%0d want=%0d", d, cyc - e.edge_n, n + 1);
                end
                last_prod[d] = e.prod;
            end
        end else begin
            vec++;
            if (p != last_prod[d]) begin
                err++;
                $display("FAIL prod_hold[%0d] cyc=%0d got=%0d want=%0d", d, cyc, p, last_prod[d]);
            end
            if (sb[d].size() > 0 && cyc > sb[d][0].edge_n + n + 1) begin
                vec++;
                err++;
                $display("FAIL missing_done[%0d] cyc=%0d got=none want=%0d", d, cyc, sb[d][0].prod);
                void'(sb[d].pop_front());
            end
        end
    endtask

    always @(posedge clk) begin
        cyc = cyc + 1;
        model_edge(0, 8, start_a, longint'(mcand_a), longint'(mplier_a));
        model_edge(1, 4, start_b, longint'(mcand_b), longint'(mplier_b));
    end

    always @(negedge clk) begin
        mon(0, 8, done_a, busy_a, longint'(prod_a));
        mon(1, 4, done_b, busy_b, longint'(prod_b));
    end

    always @(negedge rst) begin
        sb[0].delete();
        sb[1].delete();
        k[0] = -100;
        k[1] = -100;
        last_prod[0] = 0;
        last_prod[1] = 0;
    end

    task automatic issue_a(input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        mcand_a  = a;
        mplier_a = b;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
    endtask

    task automatic wait_done_a();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_a) return;
        end
        vec++;
        err++;
        $display("FAIL done_timeout got=none want=done within 30 cycles");
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sb[0].size() == 0 && sb[1].size() == 0 && !busy_a && !busy_b) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        vec++;
        err++;
        $display("FAIL drain_timeout got=pending want=idle");
    endtask

    task automatic check_zero(input string name);
        vec++;
        if (prod_a !== 16'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            err++;
            $display("FAIL %s got=prod %0d busy %0d done %0d want=0 0 0",
                     name, prod_a, busy_a, done_a);
        end
    endtask

    initial begin
        rst      = 1'b1;
        start_a  = 1'b0;
        mcand_a  = '0;
        mplier_a = '0;
        start_b  = 1'b0;
        mcand_b  = '0;
        mplier_b = '0;
        #2 rst = 1'b0;
        #1 check_zero("reset_state");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);

        issue_a(8'd13, 8'd11);
        drain();

        issue_a(8'd255, 8'd255);
        drain();
        issue_a(8'd0, 8'd200);
        drain();
        issue_a(8'd200, 8'd0);
        drain();
        issue_a(8'd1, 8'd1);
        drain();

        // second request while busy must be dropped
        issue_a(8'd7, 8'd9);
        repeat (2) @(negedge clk);
        mcand_a  = 8'd100;
        mplier_a = 8'd100;
        start_a  = 1'b1;
        @(negedge clk);
        start_a  = 1'b0;
        drain();

        @(negedge clk);
        mcand_a  = 8'd10;
        mplier_a = 8'd20;
        start_a  = 1'b1;
        wait_done_a();
        mcand_a  = 8'd3;
        mplier_a = 8'd5;
        wait_done_a();
        start_a  = 1'b0;
        drain();

        issue_a(8'd50, 8'd60);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_zero("reset_midop");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (15) @(negedge clk);
        issue_a(8'd2, 8'd3);
        drain();

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start_a  = ($urandom_range(0, 2) == 0);
            mcand_a  = 8'($urandom);
            mplier_a = 8'($urandom);
        end
        start_a = 1'b0;
        drain();

        @(negedge clk);
        mcand_b  = 12'd4095;
        mplier_b = 4'd15;
        start_b  = 1'b1;
        @(negedge clk);
        start_b  = 1'b0;
        drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start_b  = ($urandom_range(0, 1) == 0);
            mcand_b  = 12'($urandom);
            mplier_b = 4'($urandom);
        end
        start_b = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/seq_mult.md
# seq_mult

Sequential unsigned shift-and-add multiplier. It is the arithmetic counterpart of the team's sequential restoring divider, and shares the same start/done control style and registered outputs. It takes one multiplier bit per clock and returns a full-width product after a fixed latency. Datapath blocks use it as a drop-in where an area-cheap multiply is acceptable.

## Interface
- MCAND_WIDTH, default 8: multiplicand width, ≥ 2
- MPLIER_WIDTH, default 8: multiplier width N, ≥ 2; also the iteration count
- PROD_WIDTH, default MCAND_WIDTH+MPLIER_WIDTH: product width; must equal the sum, and other values are illegal
- clk  input  1: clock, rising edge
- rst  input  1: reset, asynchronous, active-low
- start  input  1: request; sampled only in IDLE
- mcand_in  input  MCAND_WIDTH: multiplicand, captured on the accepting edge
- mplier_in  input  MPLIER_WIDTH: multiplier, captured on the accepting edge
- prod_out  output  PROD_WIDTH: registered product; holds the last result
- busy  output  1: high in RUN and DONE
- done  output  1: one-cycle pulse when prod_out is updated

## Operation
- State machine has three states: IDLE, RUN, DONE.
- Internal registers:
  - mcand_r (MCAND_WIDTH)
  - acc (PROD_WIDTH+1, with a carry bit on top; upper part holds the partial sum, lower N bits hold the multiplier)
  - cnt (clog2(N) bits)
- IDLE:
  - On start=1: mcand_r ← mcand_in, acc ← {0, zeros, mplier_in}, cnt ← 0, then go to RUN.
  - On start=0: all registers hold.
- RUN, each cycle:
  - If acc[0]=1, the upper MCAND_WIDTH+1 bits ← acc upper bits + mcand_r. This is an unsigned add; the carry lands in the top bit.
  - The whole acc is then shifted right by 1 logically. The add and shift happen on one edge.
  - cnt ← cnt+1.
  - If cnt = N-1 on this edge, go to DONE.
- DONE: prod_out ← acc[PROD_WIDTH-1:0], done ← 1, then go to IDLE.
- done is 0 in every other cycle. prod_out changes only on the DONE edge.
- start while busy=1 is ignored: no queuing and no effect on the current operation.
- Operand inputs are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- Overflow is impossible: the product always fits PROD_WIDTH.
- Zero operands need no special case; they run the full latency.
- Reset (rst=0, any time, including mid-operation) forces the following immediately:
  - state = IDLE; mcand_r, acc and cnt = 0.
  - prod_out = 0, busy = 0, done = 0.
  - An in-flight operation is discarded and no done is produced for it.
- Reset values of the outputs: prod_out 0, busy 0, done 0.

## Timing
- Edge E0: start=1 sampled in IDLE. busy is high after E0.
- Edges E1..EN: the N RUN iterations. State = DONE after EN.
- Edge EN+1:
  - prod_out valid and done=1, both from this edge until EN+2.
  - busy=0 after this edge.
- Latency from the accepting edge to done is N+1 clocks: 9 clocks for the defaults.
- Back-to-back operation:
  - The state is IDLE in the cycle where done=1.
  - A start=1 in that cycle is accepted at EN+2.
  - Issue interval is N+2 clocks.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic multiply:
  - Stimulus: mcand=13, mplier=11, start pulse.
  - Required: done exactly 9 clocks after the accepting edge, prod_out=143, busy high for 9 cycles, done high for 1 cycle.
- Corner operands:
  - Stimulus: 255×255, then 0×200, then 200×0, then 1×1.
  - Required: prod_out = 65025, 0, 0, 1 respectively, each with latency 9.
- Input changes and start while busy:
  - Stimulus: start with 7×9; 3 cycles later drive mcand=100, mplier=100 and pulse start again.
  - Required: a single done with prod_out=63; the second start is ignored and no second done appears.
- Back-to-back:
  - Stimulus: hold start=1 continuously with 10×20, then switch the operands to 3×5 in the done cycle.
  - Required: done pulses 10 clocks apart, carrying 200 then 15; prod_out holds 200 between the pulses.
- Reset mid-operation:
  - Stimulus: assert rst=0 asynchronously 4 cycles into 50×60.
  - Required: prod_out, busy and done go to 0 immediately; no done follows.
  - Follow-up: after release, 2×3 yields 6 with nominal latency.
- Parameter sweep:
  - Stimulus: MCAND_WIDTH=12, MPLIER_WIDTH=4; run 4095×15, then random operands against a reference model.
  - Required: 4095×15 gives 61425 with latency 5; every random result matches the model.
